pipelined_regfile: RTL

//  Multi-port, clocked register file for the pipelined MIPS datapath; replaces the single-port,

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_read_port.sv | 84 ++++++++
 rtl/pipelined_regfile.sv | 75 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined register file.
// Optional feature macro: WR_BYPASS_EN (same-cycle write-to-read bypass in the read ports).
package regfile_pkg;

    // Default geometry of the MIPS integer register file
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architecturally significant register indices
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Register address at the default geometry
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port of the pipelined register file.
// Selects a word from the flattened storage, optionally forwards a same-cycle write
// (macro WR_BYPASS_EN), forces register 0 to zero when ZERO_REG is set, and registers
// the result together with a one-cycle valid flag.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chip_select,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0] mem_flat,
    input  logic                          wr_fire,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] word_arr [DEPTH];
    logic [DATA_W-1:0] read_word;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              rd_accept;

    // Unpacked view of the storage so the address mux is a plain array index
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign word_arr[gi] = mem_flat[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign rd_accept = chip_select & rd_en;

`ifdef WR_BYPASS_EN
    // Stored word, replaced by the write data when the write lands on the same address
    always_comb begin
        read_word = word_arr[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) begin
            read_word = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO))) begin
            read_word = '0;
        end
    end
`else
    // The write path is not needed when reads see the pre-write contents
    logic unused_bypass;
    assign unused_bypass = ^{wr_fire, wr_addr, wr_data};

    // Stored word (pre-write value on a same-cycle hit), zero register forced to 0
    always_comb begin
        read_word = word_arr[rd_addr];
        if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO))) begin
            read_word = '0;
        end
    end
`endif

    // Output registers: capture on an accepted read, otherwise hold data and drop valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (rd_accept) begin
            rd_data_reg  <= read_word;
            rd_valid_reg <= 1'b1;
        end else begin
            rd_valid_reg <= 1'b0;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/pipelined_regfile.sv
// Multi-port clocked register file for the ID stage of the pipelined MIPS datapath.
// NUM_RD synchronous read ports, one synchronous write port, optional hard-wired r0.
// Optional feature macro: WR_BYPASS_EN (reads see a same-cycle write to their address).
module pipelined_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     chip_select,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic                    wr_fire;

    assign wr_fire = chip_select & wr_en;

    genvar gi;
    generate
        // Storage: one register per address; r0 is a constant when hard-wired to zero
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            if ((ZERO_REG != 0) && (gi == REG_ZERO)) begin : g_zero
                assign mem_flat[gi*DATA_W +: DATA_W] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] word_reg;

                // Write port: update this word when the write targets its address
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
                        word_reg <= wr_data;
                    end
                end

                assign mem_flat[gi*DATA_W +: DATA_W] = word_reg;
            end
        end

        // Independent read ports sharing the storage and the write path
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_read_port (
                .clk         (clk),
                .rst_n       (rst_n),
                .chip_select (chip_select),
                .rd_en       (rd_en[gi]),
                .rd_addr     (rd_addr[gi*ADDR_W +: ADDR_W]),
                .mem_flat    (mem_flat),
                .wr_fire     (wr_fire),
                .wr_addr     (wr_addr),
                .wr_data     (wr_data),
                .rd_data     (rd_data[gi*DATA_W +: DATA_W]),
                .rd_valid    (rd_valid[gi])
            );
        end
    endgenerate

endmodule
